// File: rtl/sram_address_calc_if.sv
// Bus bundle for the SRAM address generator: pointer control, row geometry,
// region base addresses and the resulting SRAM address.
interface sram_address_calc_if #(
  parameter int ADDR_W  = 26,
  parameter int WIDTH_W = 13
);
  logic               clear;
  logic               mode;
  logic               enable;
  logic [WIDTH_W-1:0] image_width;
  logic [ADDR_W-1:0]  sram_rowCacheStart;
  logic [ADDR_W-1:0]  sram_outputAddrStart;
  logic [ADDR_W-1:0]  sram_addr;

  modport master (
    output clear, mode, enable, image_width,
    output sram_rowCacheStart, sram_outputAddrStart,
    input  sram_addr
  );

  modport slave (
    input  clear, mode, enable, image_width,
    input  sram_rowCacheStart, sram_outputAddrStart,
    output sram_addr
  );
endinterface

// File: rtl/sram_address_calc.sv
// SRAM address generator with two independent offset pointers:
// a row-cache read pointer that wraps every image row and a linear
// output write pointer. mode picks which pointer (plus its base) is
// presented on sram_addr and which one advances on enable.
module sram_address_calc #(
  parameter int ADDR_W  = 26,
  parameter int WIDTH_W = 13
) (
  input logic                clk,
  input logic                rst,
  sram_address_calc_if.slave bus
);

  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;

  // One extra bit so rd_off + 1 cannot overflow before the wrap compare.
  logic [ADDR_W:0] rd_inc;
  logic [ADDR_W:0] width_ext;
  logic            rd_wrap;

  assign rd_inc    = {1'b0, rd_off} + {{ADDR_W{1'b0}}, 1'b1};
  assign width_ext = {{(ADDR_W + 1 - WIDTH_W){1'b0}}, bus.image_width};
  // Using >= (not ==) also recovers when image_width shrinks mid-row and
  // pins rd_off at 0 for widths of 0 and 1.
  assign rd_wrap   = (rd_inc >= width_ext);

  // Offset registers: reset, then clear, then enable of the selected pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_off <= '0;
      wr_off <= '0;
    end else if (bus.clear) begin
      rd_off <= '0;
      wr_off <= '0;
    end else if (bus.enable) begin
      if (bus.mode) begin
        rd_off <= rd_wrap ? '0 : rd_inc[ADDR_W-1:0];
      end else begin
        wr_off <= wr_off + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Address output: selected base plus its offset, modulo 2^ADDR_W.
  always_comb begin
    bus.sram_addr = '0;
    if (bus.mode) begin
      bus.sram_addr = bus.sram_rowCacheStart + rd_off;
    end else begin
      bus.sram_addr = bus.sram_outputAddrStart + wr_off;
    end
  end

endmodule

// File: tb/tb_sram_address_calc.sv
// Self-checking bench for sram_address_calc: a constant vector table,
// directed sequences for the row-wrap / clear / reset corner cases, and a
// randomized run against an arithmetic reference model.
module tb_sram_address_calc;
  localparam int ADDR_W  = 26;
  localparam int WIDTH_W = 13;
  localparam longint MOD = 64'd1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  sram_address_calc_if #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) bus ();

  sram_address_calc #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference offsets held as plain integers.
  longint m_rd = 0;
  longint m_wr = 0;

  typedef struct {
    bit           rst;
    bit           clr;
    bit           mode;
    bit           en;
    int unsigned  w;
    logic [25:0]  rb;
    logic [25:0]  ob;
    logic [25:0]  exp;
  } vec_t;

  vec_t vecs[12];

  // Advance the model by the rules for one rising edge with current inputs.
  task automatic model_edge();
    if (rst) begin
      m_rd = 0;
      m_wr = 0;
    end else if (bus.clear) begin
      m_rd = 0;
      m_wr = 0;
    end else if (bus.enable) begin
      if (bus.mode) begin
        if (m_rd + 1 >= longint'(bus.image_width)) m_rd = 0;
        else m_rd = m_rd + 1;
      end else begin
        m_wr = (m_wr + 1) % MOD;
      end
    end
  endtask

  function automatic logic [25:0] model_addr();
    longint s;
    if (bus.mode) s = (longint'(bus.sram_rowCacheStart) + m_rd) % MOD;
    else s = (longint'(bus.sram_outputAddrStart) + m_wr) % MOD;
    return s[25:0];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [25:0] exp);
    #1;
    n_cmp++;
    if (bus.sram_addr !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, bus.sram_addr, exp);
    end
  endtask

  task automatic set_in(input bit c, input bit m, input bit e);
    bus.clear  = c;
    bus.mode   = m;
    bus.enable = e;
  endtask

  initial begin
    // rst clr mode en  w   rb   ob   expected after edge
    vecs[0]  = '{1, 0, 1, 0, 3, 100, 200, 100};
    vecs[1]  = '{0, 0, 1, 1, 3, 100, 200, 101};
    vecs[2]  = '{0, 0, 1, 1, 3, 100, 200, 102};
    vecs[3]  = '{0, 0, 1, 1, 3, 100, 200, 100};
    vecs[4]  = '{0, 0, 0, 1, 3, 100, 200, 201};
    vecs[5]  = '{0, 0, 1, 0, 3, 100, 200, 100};
    vecs[6]  = '{0, 0, 1, 1, 3, 100, 200, 101};
    vecs[7]  = '{0, 1, 1, 1, 3, 100, 200, 100};
    vecs[8]  = '{0, 0, 0, 0, 3, 100, 200, 200};
    vecs[9]  = '{0, 0, 0, 1, 3, 100, 200, 201};
    vecs[10] = '{0, 0, 1, 1, 3, 100, 200, 101};
    vecs[11] = '{1, 0, 0, 1, 3, 100, 200, 200};

    rst = 1'b1;
    set_in(0, 1, 0);
    bus.image_width          = 13'd3;
    bus.sram_rowCacheStart   = 26'd100;
    bus.sram_outputAddrStart = 26'd200;
    @(posedge clk);
    #1;

    // Vector table.
    foreach (vecs[i]) begin
      rst                      = vecs[i].rst;
      bus.image_width          = 13'(vecs[i].w);
      bus.sram_rowCacheStart   = vecs[i].rb;
      bus.sram_outputAddrStart = vecs[i].ob;
      set_in(vecs[i].clr, vecs[i].mode, vecs[i].en);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset hold with the test-plan geometry.
    rst = 1'b1;
    set_in(0, 1, 0);
    bus.image_width          = 13'd50;
    bus.sram_rowCacheStart   = 26'd440;
    bus.sram_outputAddrStart = 26'd4400;
    repeat (10) tick();
    check("rst_mode1", 26'd440);
    bus.mode = 1'b0;
    check("rst_mode0", 26'd4400);
    rst = 1'b0;
    tick();
    check("rst_release_mode0", 26'd4400);
    bus.mode = 1'b1;
    check("rst_release_mode1", 26'd440);

    // Row read sweep: one pulse every two cycles, 50 pulses.
    for (int k = 1; k <= 50; k++) begin
      set_in(0, 1, 1);
      tick();
      bus.enable = 1'b0;
      if (k < 50) check($sformatf("sweep%0d_m1", k), 26'(440 + k));
      else check("sweep_wrap", 26'd440);
      bus.mode = 1'b0;
      check($sformatf("sweep%0d_m0", k), 26'd4400);
      bus.mode = 1'b1;
      tick();
    end

    // Output write run.
    for (int k = 1; k <= 10; k++) begin
      set_in(0, 0, 1);
      tick();
      check($sformatf("wr%0d", k), 26'(4400 + k));
    end
    set_in(0, 1, 0);
    check("wr_rd_untouched", 26'd440);

    // Clear after 7 reads (10 writes already done).
    for (int k = 0; k < 7; k++) begin
      set_in(0, 1, 1);
      tick();
    end
    check("pre_clear_rd", 26'd447);
    set_in(1, 1, 0);
    tick();
    check("clear_m1", 26'd440);
    set_in(0, 0, 0);
    check("clear_m0", 26'd4400);
    set_in(0, 1, 1);
    tick();
    set_in(0, 0, 1);
    tick();
    set_in(1, 1, 1);
    tick();
    check("clear_en_m1", 26'd440);
    set_in(1, 0, 1);
    tick();
    check("clear_en_m0", 26'd4400);

    // Interleaved read/write enables.
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 1, 1);
      tick();
      check($sformatf("il_rd%0d", k), 26'(440 + k));
      set_in(0, 0, 1);
      tick();
      check($sformatf("il_wr%0d", k), 26'(4400 + k));
    end

    // image_width reduced mid-row wraps on the next read enable.
    set_in(0, 1, 1);
    repeat (6) tick();
    check("pre_shrink", 26'd450);
    bus.image_width = 13'd5;
    tick();
    check("shrink_wrap", 26'd440);

    // Degenerate widths keep rd_off at 0.
    bus.image_width = 13'd1;
    repeat (3) begin
      tick();
      check("width1", 26'd440);
    end
    bus.image_width = 13'd0;
    tick();
    check("width0", 26'd440);

    // Output base at top of address space wraps.
    set_in(1, 0, 0);
    tick();
    bus.sram_outputAddrStart = 26'h3FF_FFFF;
    check("top_base", 26'h3FF_FFFF);
    set_in(0, 0, 1);
    tick();
    check("top_wrap", 26'd0);
    bus.sram_outputAddrStart = 26'd4400;

    // Reset mid-run.
    bus.image_width = 13'd50;
    set_in(1, 1, 0);
    tick();
    set_in(0, 1, 1);
    repeat (25) tick();
    check("mid_pre", 26'd465);
    set_in(0, 0, 1);
    tick();
    rst = 1'b1;
    set_in(0, 1, 0);
    tick();
    rst = 1'b0;
    check("mid_rst_m1", 26'd440);
    bus.mode = 1'b0;
    check("mid_rst_m0", 26'd4400);
    set_in(0, 1, 1);
    tick();
    check("mid_rst_next", 26'd441);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.clear  = ($urandom_range(0, 49) == 0);
      bus.mode   = $urandom_range(0, 1);
      bus.enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) bus.image_width = 13'($urandom_range(0, 20));
      if ($urandom_range(0, 127) == 0) bus.sram_rowCacheStart = 26'($urandom);
      if ($urandom_range(0, 127) == 0) bus.sram_outputAddrStart = 26'($urandom);
      tick();
      check($sformatf("rnd%0d", i), model_addr());
      bus.mode = ~bus.mode;
      check($sformatf("rnd%0d_other", i), model_addr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_address_calc.md
Name: sram_address_calc

Overview:
- Generates the SRAM address for the image-processing datapath.
- Holds two independent offset counters: a row-cache read pointer and an output write pointer.
- `mode` selects which pointer drives `sram_addr`. The selected pointer advances one word per `enable`.
- The row-cache pointer wraps after one image row (`image_width` words). The output pointer runs linearly.

Parameters:
- ADDR_W, 26, width of SRAM addresses, start bases and offset counters
- WIDTH_W, 13, width of `image_width`

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous clear of both offset counters
- mode  input  1  1 = row-cache read pointer selected, 0 = output write pointer selected
- enable  input  1  advance the pointer selected by `mode` by one
- image_width  input  WIDTH_W  row length in words; wrap point for the row-cache pointer
- sram_rowCacheStart  input  ADDR_W  base address of the row cache
- sram_outputAddrStart  input  ADDR_W  base address of the output region
- sram_addr  output  ADDR_W  current SRAM address

Behaviour:
- State: `rd_off` (ADDR_W bits, row-cache offset) and `wr_off` (ADDR_W bits, output offset). Both are registered.
- Output is combinational from the registered offsets and the current inputs:
  - mode=1: `sram_addr = sram_rowCacheStart + rd_off`
  - mode=0: `sram_addr = sram_outputAddrStart + wr_off`
  - Addition is modulo 2^ADDR_W.
  - Base or `mode` changes reflect on `sram_addr` in the same cycle, with no added latency.
- Reset:
  - On a rising edge with rst=1, `rd_off` and `wr_off` go to 0.
  - While rst stays high, `sram_addr` equals the selected start base (follows `mode` combinationally).
- Clear:
  - On a rising edge with rst=0 and clear=1, both offsets go to 0.
  - `enable` is ignored that cycle.
- Enable (rst=0, clear=0, enable=1), at the rising edge:
  - mode=1: if `rd_off + 1 >= image_width`, then `rd_off` becomes 0; else `rd_off` increments. `wr_off` holds.
  - mode=0: `wr_off` increments modulo 2^ADDR_W (no wrap against `image_width`). `rd_off` holds.
- Priority: rst > clear > enable. With enable=0, both offsets hold.
- Row wrap: after exactly `image_width` enables in mode=1, `rd_off` is back at 0 and `sram_addr` equals `sram_rowCacheStart` again. The last in-row address is `sram_rowCacheStart + image_width - 1`.
- Degenerate widths: `image_width` of 0 or 1 keeps `rd_off` at 0 permanently.
- `image_width` reduced mid-row: if `rd_off` is already >= the new `image_width - 1`, the next mode=1 enable wraps `rd_off` to 0.
- The two pointers are fully independent:
  - Toggling `mode` never alters either offset.
  - Interleaved read/write enables each advance only their own pointer.
- Reset asserted mid-operation discards both offsets on the next rising edge.
- No internal pipelining.
- Single clock domain. All inputs are assumed synchronous to `clk`.

Test Plan:
- Reset: `image_width`=50, rowCacheStart=440, outputAddrStart=4400, rst=1 for 10 cycles with mode=1 -> `sram_addr`=440. Switch mode=0 -> `sram_addr`=4400. Release rst -> values unchanged.
- Row read sweep: mode=1, pulse `enable` once per 2 cycles, 50 times. After pulse k (k=1..49), mode=1 gives 440+k and mode=0 gives 4400. After pulse 50, mode=1 gives 440 (wrap).
- Output write run: mode=0, 10 enable pulses -> `sram_addr` 4401..4410 in turn. mode=1 still shows the unchanged row-cache address.
- Clear: after 7 row-cache and 10 output enables, pulse clear for 1 cycle -> mode=1 gives 440, mode=0 gives 4400. A simultaneous enable+clear must leave both offsets at 0.
- Interleave and boundaries:
  - Alternate mode=1/mode=0 enables -> each pointer advances only on its own mode.
  - `image_width`=1 -> `rd_off` stays 0.
  - outputAddrStart=2^26-1 with one write enable -> `sram_addr` wraps to 0.
- Reset mid-run: after 25 row-cache enables, assert rst for 1 cycle -> mode=1 gives 440, mode=0 gives 4400. The next enable in mode=1 -> 441.
